// File: rtl/b2b_bundle_ctrl.sv
// Sequential front-end of the binarized back-to-back bundling path.
// Holds the running bundle, derives an equal-weight flip value for each new
// vector with a restoring divider, drives the manipulator and merges its mask.
module b2b_bundle_ctrl #(
  parameter int VALUE_WIDTH = 7,
  parameter int VEC_WIDTH   = 2048,  // memory row width; multiple of 2**(VALUE_WIDTH+1)
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   vec_valid_i,
  output logic                   vec_ready_o,
  input  logic [VEC_WIDTH-1:0]   vec_i,
  input  logic                   vec_last_i,
  output logic                   bundle_valid_o,
  input  logic                   bundle_ready_i,
  output logic [VEC_WIDTH-1:0]   bundle_o,
  output logic [CNT_WIDTH-1:0]   bundle_count_o,
  output logic                   man_en_o,
  output logic [VALUE_WIDTH-1:0] man_value_o,
  input  logic [VEC_WIDTH-1:0]   man_mask_i
);

  // Quotient needs one bit more than the dividend 2**(VALUE_WIDTH+1) has zeros.
  localparam int QW      = VALUE_WIDTH + 2;
  // Divisor n+1 is one bit wider than the counter so it never wraps.
  localparam int DW      = CNT_WIDTH + 1;
  localparam int STEP_W  = $clog2(QW);
  localparam int VAL_MAX = (1 << VALUE_WIDTH) - 1;

  typedef enum logic [1:0] {IDLE, DIV, MIX, OUT} state_t;

  state_t                 state_reg, state_next;
  logic [VEC_WIDTH-1:0]   acc_reg;
  logic [VEC_WIDTH-1:0]   vreg_reg;
  logic [CNT_WIDTH-1:0]   count_reg;
  logic                   last_reg;
  logic [DW-1:0]          divisor_reg;
  logic [DW-1:0]          rem_reg;
  logic [QW-1:0]          quo_reg;
  logic [STEP_W-1:0]      step_reg;

  logic                   dividend_bit;
  logic [DW:0]            rem_shift;
  logic                   rem_ge;
  logic [DW-1:0]          rem_next;
  logic [VALUE_WIDTH-1:0] sat_value;
  logic [VEC_WIDTH-1:0]   mix_vec;

  // The dividend is a single one followed by zeros, fed MSB first.
  assign dividend_bit = (step_reg == '0);
  assign rem_shift    = {rem_reg, dividend_bit};
  assign rem_ge       = (rem_shift >= {1'b0, divisor_reg});
  // The difference is below the divisor, so the low DW bits are exact.
  assign rem_next     = rem_ge ? (rem_shift[DW-1:0] - divisor_reg) : rem_shift[DW-1:0];
  assign sat_value    = (quo_reg > QW'(VAL_MAX)) ? VALUE_WIDTH'(VAL_MAX)
                                                 : quo_reg[VALUE_WIDTH-1:0];

  // Per-bit merge: flipped positions take the new vector, others keep the bundle.
  genvar gi;
  generate
    for (gi = 0; gi < VEC_WIDTH; gi++) begin : g_mix
      assign mix_vec[gi] = man_mask_i[gi] ? vreg_reg[gi] : acc_reg[gi];
    end
  endgenerate

  assign bundle_o       = acc_reg;
  assign bundle_count_o = count_reg;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state and handshake/manipulator outputs; clear overrides everything.
  always_comb begin
    state_next     = state_reg;
    vec_ready_o    = 1'b0;
    bundle_valid_o = 1'b0;
    man_en_o       = 1'b0;
    man_value_o    = '0;
    case (state_reg)
      IDLE: begin
        vec_ready_o = 1'b1;
        if (vec_valid_i) begin
          if (count_reg == '0) state_next = vec_last_i ? OUT : IDLE;
          else                 state_next = DIV;
        end
      end
      DIV: begin
        if (step_reg == STEP_W'(QW - 1)) state_next = MIX;
      end
      MIX: begin
        man_en_o    = 1'b1;
        man_value_o = sat_value;
        state_next  = last_reg ? OUT : IDLE;
      end
      OUT: begin
        bundle_valid_o = 1'b1;
        if (bundle_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (clear_i) state_next = IDLE;
  end

  // Accumulator, counter and divider datapath.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_reg     <= '0;
      vreg_reg    <= '0;
      count_reg   <= '0;
      last_reg    <= 1'b0;
      divisor_reg <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      step_reg    <= '0;
    end else if (clear_i) begin
      count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (vec_valid_i) begin
            if (count_reg == '0) begin
              acc_reg   <= vec_i;
              count_reg <= CNT_WIDTH'(1);
            end else begin
              vreg_reg    <= vec_i;
              last_reg    <= vec_last_i;
              divisor_reg <= DW'(count_reg) + DW'(1);
              rem_reg     <= '0;
              quo_reg     <= '0;
              step_reg    <= '0;
            end
          end
        end
        DIV: begin
          rem_reg  <= rem_next;
          quo_reg  <= {quo_reg[QW-2:0], rem_ge};
          step_reg <= step_reg + STEP_W'(1);
        end
        MIX: begin
          acc_reg <= mix_vec;
          if (count_reg != '1) count_reg <= count_reg + CNT_WIDTH'(1);
        end
        OUT: begin
          if (bundle_ready_i) count_reg <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_b2b_bundle_ctrl.sv
// Self-checking bench for b2b_bundle_ctrl: a bench model predicts flip values
// and bundles, a stub manipulator returns a chosen mask during MIX.
module tb_b2b_bundle_ctrl;

  localparam int VW = 7;
  localparam int W  = 2048;
  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          clear_i;
  logic          vec_valid_i;
  logic          vec_ready_o;
  logic [W-1:0]  vec_i;
  logic          vec_last_i;
  logic          bundle_valid_o;
  logic          bundle_ready_i;
  logic [W-1:0]  bundle_o;
  logic [CW-1:0] bundle_count_o;
  logic          man_en_o;
  logic [VW-1:0] man_value_o;
  logic [W-1:0]  man_mask_i;
  logic [W-1:0]  cur_mask;

  b2b_bundle_ctrl #(.VALUE_WIDTH(VW), .VEC_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .vec_valid_i(vec_valid_i), .vec_ready_o(vec_ready_o), .vec_i(vec_i),
    .vec_last_i(vec_last_i), .bundle_valid_o(bundle_valid_o),
    .bundle_ready_i(bundle_ready_i), .bundle_o(bundle_o),
    .bundle_count_o(bundle_count_o), .man_en_o(man_en_o),
    .man_value_o(man_value_o), .man_mask_i(man_mask_i)
  );

  always #5 clk_i = ~clk_i;

  // Stub manipulator: combinational mask while enabled, zero otherwise.
  assign man_mask_i = man_en_o ? cur_mask : '0;

  typedef struct {
    logic [W-1:0] vec;
    int           cnt;
  } bundle_t;

  bundle_t      exp_q[$];
  int           val_q[$];
  logic [W-1:0] m_acc;
  int           m_cnt;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           en_seen = 0;

  // Count manipulator enable cycles for the "never asserted" checks.
  always @(negedge clk_i) if (man_en_o) en_seen++;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (%0d bits differ)", tag, obs[63:0], exp[63:0],
               $countones(obs ^ exp));
    end
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Present a vector from a negedge and return at the negedge after the accept edge.
  task automatic accept(input logic [W-1:0] vec, input logic last);
    int t = 0;
    vec_i = vec;
    vec_last_i = last;
    vec_valid_i = 1'b1;
    while (!vec_ready_o && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 100) check("accept_timeout", 0, 1);
    @(negedge clk_i);
    vec_valid_i = 1'b0;
    vec_last_i = 1'b0;
  endtask

  // Update the model, drive one vector and check divider/MIX timing.
  task automatic send(input logic [W-1:0] vec, input logic last);
    bit first;
    int q, val, k, ready_hi, exp_val;
    first = (m_cnt == 0);
    if (first) begin
      m_acc = vec;
      m_cnt = 1;
    end else begin
      q = (1 << (VW + 1)) / (m_cnt + 1);
      val = (q > (1 << VW) - 1) ? (1 << VW) - 1 : q;
      cur_mask = (val == 0) ? '0 : rand_vec();
      m_acc = (m_acc & ~cur_mask) | (vec & cur_mask);
      if (m_cnt < (1 << CW) - 1) m_cnt++;
      val_q.push_back(val);
    end
    if (last) exp_q.push_back('{vec: m_acc, cnt: m_cnt});
    accept(vec, last);
    if (first) begin
      if (last) check("single_valid", bundle_valid_o, 1);
      else      check("first_rearm", vec_ready_o, 1);
      return;
    end
    k = 1;
    ready_hi = 0;
    while (!man_en_o && k < 20) begin
      if (vec_ready_o) ready_hi++;
      @(negedge clk_i);
      k++;
    end
    if (!man_en_o) begin
      check("mix_timeout", 0, 1);
      return;
    end
    if (vec_ready_o) ready_hi++;
    check("mix_latency", k, 10);
    check("div_ready_low", ready_hi, 0);
    exp_val = val_q.pop_front();
    check("man_value", man_value_o, exp_val);
    @(negedge clk_i);
    check("mix_one_cycle", man_en_o, 0);
    if (last) check("valid_after_mix", bundle_valid_o, 1);
    else      check("rearm_ready", vec_ready_o, 1);
  endtask

  // Wait for a bundle, compare against the scoreboard, optionally backpressure.
  task automatic receive(input int hold);
    int t = 0, chg = 0, rdy = 0;
    bundle_t e;
    logic [W-1:0] snap_v;
    logic [CW-1:0] snap_c;
    while (!bundle_valid_o && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    if (!bundle_valid_o) begin
      check("bundle_timeout", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check("bundle_vec", bundle_o, e.vec);
    check("bundle_count", bundle_count_o, e.cnt);
    $display("bundle: count=%0d low_word=%h", bundle_count_o, bundle_o[63:0]);
    snap_v = bundle_o;
    snap_c = bundle_count_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      if (!bundle_valid_o || bundle_o !== snap_v || bundle_count_o !== snap_c) chg++;
      if (vec_ready_o) rdy++;
    end
    if (hold > 0) begin
      check("bp_stable", chg, 0);
      check("bp_ready_low", rdy, 0);
    end
    bundle_ready_i = 1'b1;
    @(negedge clk_i);
    bundle_ready_i = 1'b0;
    check("out_to_idle", vec_ready_o, 1);
    check("valid_drop", bundle_valid_o, 0);
    m_cnt = 0;
  endtask

  initial begin
    logic [W-1:0] a, ones;
    int en_before, k;
    rst_ni = 1'b0;
    clear_i = 1'b0;
    vec_valid_i = 1'b0;
    vec_last_i = 1'b0;
    vec_i = '0;
    bundle_ready_i = 1'b0;
    cur_mask = '0;
    m_acc = '0;
    m_cnt = 0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_ready", vec_ready_o, 1);
    check("rst_valid", bundle_valid_o, 0);
    check("rst_en", man_en_o, 0);
    check("rst_count", bundle_count_o, 0);
    check("rst_bundle", bundle_o, '0);

    // Single-vector bundle: returned unchanged, manipulator untouched.
    en_before = en_seen;
    send(rand_vec(), 1'b1);
    receive(0);
    check("single_no_en", en_seen - en_before, 0);

    // Two vectors.
    send(rand_vec(), 1'b0);
    send(rand_vec(), 1'b1);
    receive(0);

    // Four vectors: values 127, 85, 64.
    for (int i = 0; i < 4; i++) send(rand_vec(), i == 3);
    receive(0);

    // Three vectors with backpressure, then a fresh first vector.
    for (int i = 0; i < 3; i++) send(rand_vec(), i == 2);
    receive(20);
    send(rand_vec(), 1'b1);
    receive(0);

    // 300 identical all-ones vectors: flip value reaches zero from vector 257.
    ones = '1;
    for (int i = 0; i < 300; i++) send(ones, i == 299);
    receive(0);

    // Clear during DIV.
    send(rand_vec(), 1'b0);
    accept(rand_vec(), 1'b0);
    repeat (3) @(negedge clk_i);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    m_cnt = 0;
    check("clr_ready", vec_ready_o, 1);
    check("clr_en", man_en_o, 0);
    check("clr_count", bundle_count_o, 0);
    en_before = en_seen;
    repeat (12) @(negedge clk_i);
    check("clr_no_mix", en_seen - en_before, 0);

    // Clear together with a handshake: the vector is dropped.
    vec_i = rand_vec();
    vec_valid_i = 1'b1;
    clear_i = 1'b1;
    check("clr_hs_ready", vec_ready_o, 1);
    @(negedge clk_i);
    vec_valid_i = 1'b0;
    clear_i = 1'b0;
    check("clr_hs_dropped", bundle_count_o, 0);
    send(rand_vec(), 1'b1);
    receive(0);

    // Reset pulse during MIX.
    send(rand_vec(), 1'b0);
    accept(rand_vec(), 1'b0);
    k = 0;
    while (!man_en_o && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    check("rst_mix_reached", man_en_o, 1);
    rst_ni = 1'b0;
    #1;
    check("rst_mix_en", man_en_o, 0);
    check("rst_mix_count", bundle_count_o, 0);
    check("rst_mix_bundle", bundle_o, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    m_cnt = 0;
    void'(val_q.pop_front());
    @(negedge clk_i);
    a = rand_vec();
    send(a, 1'b1);
    receive(0);

    check("scoreboard_empty", exp_q.size(), 0);
    check("values_empty", val_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/b2b_bundle_ctrl.md
Name: b2b_bundle_ctrl

Overview:
- Sequential front-end of the CIM binarized back-to-back bundling path in the HD encoder.
- Accepts a stream of HD vectors and holds the running bundle in an accumulator register.
- For each new vector it computes the flip value for an equal-weight contribution with an iterative divider. It drives the manipulator module's en/value inputs and merges the returned selection mask into the accumulator.
- Emits the finished bundle on a valid/ready output.

Parameters:
- VALUE_WIDTH, 7: width of man_value_o. Must equal the manipulator's VALUE_WIDTH.
- VEC_WIDTH, pkg_common::MEM_ROW_WIDTH: HD vector width. Must be a multiple of 2**(VALUE_WIDTH+1).
- CNT_WIDTH, 16: width of the bundled-vector counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous abort; discards the current bundle.
- vec_valid_i  in  1  input vector valid.
- vec_ready_o  out  1  input vector ready.
- vec_i  in  VEC_WIDTH  input HD vector.
- vec_last_i  in  1  marks the final vector of a bundle; qualified by the handshake.
- bundle_valid_o  out  1  bundle result valid.
- bundle_ready_i  in  1  bundle result ready.
- bundle_o  out  VEC_WIDTH  accumulator contents.
- bundle_count_o  out  CNT_WIDTH  number of vectors bundled.
- man_en_o  out  1  to manipulator en_i.
- man_value_o  out  VALUE_WIDTH  to manipulator value_i.
- man_mask_i  in  VEC_WIDTH  manipulator vector_o. Integration ties manipulator vector_i to all-zero, so this is the pure flip pattern, combinational in the same cycle.

Behaviour:
- Reset (rst_ni=0, asynchronous): state=IDLE; acc, vreg, count, divider regs = 0. All outputs 0 except vec_ready_o=1 once out of reset.
- States: IDLE, DIV, MIX, OUT.
- IDLE:
  - vec_ready_o=1.
  - On vec_valid_i&vec_ready_o with count==0: acc<=vec_i, count<=1; next state OUT if vec_last_i, else IDLE.
  - With count>=1: vreg<=vec_i, last_q<=vec_last_i, n<=count; start divider; next state DIV.
- DIV:
  - Restoring divider computes q = floor(2**(VALUE_WIDTH+1) / (n+1)), one quotient bit per cycle.
  - Exactly VALUE_WIDTH+2 cycles, then MIX. vec_ready_o=0.
  - Divisor width is CNT_WIDTH+1, so n+1 never overflows.
- MIX (1 cycle):
  - man_en_o=1; man_value_o = min(q, 2**VALUE_WIDTH-1).
  - acc <= (acc & ~man_mask_i) | (vreg & man_mask_i).
  - count <= count+1, saturating at 2**CNT_WIDTH-1.
  - Next state OUT if last_q, else IDLE.
- OUT:
  - bundle_valid_o=1; bundle_o=acc and bundle_count_o=count, both stable while valid.
  - On bundle_ready_i: count<=0, next state IDLE. acc is not cleared; the next first vector overwrites it.
- Outside MIX: man_en_o=0, man_value_o=0.
- bundle_o and bundle_count_o reflect acc/count at all times; they are meaningful only when bundle_valid_o=1.
- Latency:
  - First vector: accepted in cycle 0, vec_ready_o=1 again in cycle 1.
  - Subsequent vector: accept edge cycle 0, DIV cycles 1..VALUE_WIDTH+2, MIX cycle VALUE_WIDTH+3. Next accept possible in cycle VALUE_WIDTH+4 (11 cycles for VALUE_WIDTH=7).
  - Bundle output valid the cycle after the accept (single vector) or after MIX.
- Boundaries:
  - n=1 gives q=2**VALUE_WIDTH, saturated to 2**VALUE_WIDTH-1.
  - n >= 2**(VALUE_WIDTH+1) gives q=0: no bits taken from the new vector, count still increments.
  - Count saturation leaves acc arithmetic unchanged.
  - vec_last_i on the first vector: a single-vector bundle, acc = input unchanged.
  - No input is accepted while in DIV, MIX or OUT.
- clear_i:
  - Highest priority in any state. Next cycle: state=IDLE, count=0, bundle_valid_o=0, man_en_o=0.
  - A simultaneous input handshake is ignored. vec_ready_o remains 1 in that cycle, but the vector is dropped.
- Reset mid-operation (any state): immediate return to reset values. The partial bundle is lost.

Test Plan:
- Single vector, VALUE_WIDTH=7, VEC_WIDTH=2048: vec_i=random A with vec_last_i=1 -> bundle_valid_o one cycle later, bundle_o==A, bundle_count_o==1, man_en_o never asserted.
- Two vectors A, B (last on B) -> man_en_o high exactly one cycle, 10 cycles after the B accept, with man_value_o==127; bundle_o == (A&~M)|(B&M) for the returned mask M; count==2.
- Four vectors -> man_value_o sequence 127, 85, 64 (256/3=85, 256/4=64); vec_ready_o low 10 cycles after each non-first accept; count==4.
- Bundle of 300 identical all-ones vectors -> from vector 257 onward man_value_o==0; final bundle_o all-ones; count==300.
- Backpressure: hold bundle_ready_i=0 for 20 cycles -> bundle_valid_o, bundle_o and bundle_count_o stable, vec_ready_o=0; release -> IDLE next cycle, next vector treated as first.
- clear_i asserted during DIV, and rst_ni pulsed during MIX -> IDLE, count 0, man_en_o 0 next cycle; the following single-vector bundle returns its input exactly.
